// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall request inputs and per-stage register controls of the pipeline sequencer.
// The master side is the sequencer; the slave side is the pipeline datapath.
interface pipeline_ctrl_if;
    logic hazard_stall;
    logic branch_taken;
    logic mdu_start;
    logic dmem_req;
    logic dmem_ready;

    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic mdu_busy;
    logic mdu_done;
    logic mem_err;

    modport master (
        input  hazard_stall, branch_taken, mdu_start, dmem_req, dmem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        output exmem_en, exmem_flush, memwb_en, mdu_busy, mdu_done, mem_err
    );

    modport slave (
        output hazard_stall, branch_taken, mdu_start, dmem_req, dmem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        input  exmem_en, exmem_flush, memwb_en, mdu_busy, mdu_done, mem_err
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait, MDU occupancy,
// hazard bubbles and branch flushes, with a memory-timeout trap and a stall counter.
module pipeline_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipeline_ctrl_if.master   ctrl,
    input  logic              stall_count_clr,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MDU_WAIT = 2'd2,
        ERROR    = 2'd3
    } ctrlState_e;

    localparam logic [7:0]  MDU_LOAD = 8'(MDU_LATENCY - 1);
    localparam logic [15:0] TO_LAST  = 16'(MEM_TIMEOUT - 1);

    ctrlState_e       state;
    ctrlState_e       nextState;
    logic [7:0]       mduCnt;
    logic [7:0]       mduCntNext;
    logic [15:0]      toCnt;
    logic [15:0]      toCntNext;
    logic [CNT_W-1:0] stallCountNext;
    logic             memFreeze;
    logic             active;

    assign memFreeze = ctrl.dmem_req & ~ctrl.dmem_ready;
    assign active    = (state == RUN) || (state == MDU_WAIT);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            mduCnt      <= '0;
            toCnt       <= '0;
            stall_count <= '0;
        end else begin
            state       <= nextState;
            mduCnt      <= mduCntNext;
            toCnt       <= toCntNext;
            stall_count <= stallCountNext;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        nextState        = state;
        mduCntNext       = mduCnt;
        toCntNext        = '0;
        ctrl.pc_en       = 1'b0;
        ctrl.ifid_en     = 1'b0;
        ctrl.ifid_flush  = 1'b0;
        ctrl.idex_en     = 1'b0;
        ctrl.idex_flush  = 1'b0;
        ctrl.exmem_en    = 1'b0;
        ctrl.exmem_flush = 1'b0;
        ctrl.memwb_en    = 1'b0;
        ctrl.mdu_busy    = (state == MDU_WAIT);
        ctrl.mdu_done    = 1'b0;
        ctrl.mem_err     = 1'b0;

        if (active && memFreeze) begin
            // Whole pipeline holds; the MDU countdown pauses with it.
            toCntNext = toCnt + 16'd1;
            if (toCnt == TO_LAST) begin
                nextState = ERROR;
            end
        end else begin
            case (state)
                INIT: begin
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_flush  = 1'b1;
                    ctrl.exmem_flush = 1'b1;
                    nextState        = RUN;
                end

                RUN: begin
                    if (ctrl.mdu_start) begin
                        ctrl.exmem_flush = 1'b1;
                        ctrl.exmem_en    = 1'b1;
                        ctrl.memwb_en    = 1'b1;
                        mduCntNext       = MDU_LOAD;
                        nextState        = MDU_WAIT;
                    end else if (ctrl.hazard_stall) begin
                        ctrl.idex_flush = 1'b1;
                        ctrl.idex_en    = 1'b1;
                        ctrl.exmem_en   = 1'b1;
                        ctrl.memwb_en   = 1'b1;
                    end else begin
                        ctrl.ifid_flush = ctrl.branch_taken;
                        ctrl.pc_en      = 1'b1;
                        ctrl.ifid_en    = 1'b1;
                        ctrl.idex_en    = 1'b1;
                        ctrl.exmem_en   = 1'b1;
                        ctrl.memwb_en   = 1'b1;
                    end
                end

                MDU_WAIT: begin
                    if (mduCnt != 8'd0) begin
                        ctrl.exmem_flush = 1'b1;
                        ctrl.exmem_en    = 1'b1;
                        ctrl.memwb_en    = 1'b1;
                        mduCntNext       = mduCnt - 8'd1;
                    end else begin
                        ctrl.pc_en    = 1'b1;
                        ctrl.ifid_en  = 1'b1;
                        ctrl.idex_en  = 1'b1;
                        ctrl.exmem_en = 1'b1;
                        ctrl.memwb_en = 1'b1;
                        ctrl.mdu_done = 1'b1;
                        nextState     = RUN;
                    end
                end

                ERROR: begin
                    ctrl.mem_err = 1'b1;
                end

                default: begin
                    nextState = INIT;
                end
            endcase
        end
    end

    // Clear wins over increment; the count only advances while the pipeline is live.
    always_comb begin
        stallCountNext = stall_count;
        if (stall_count_clr) begin
            stallCountNext = '0;
        end else if (active && !ctrl.pc_en && (stall_count != '1)) begin
            stallCountNext = stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one task per scenario, hand-computed expected
// control vectors {pc,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,exmem_flush,memwb}.
module tb_pipeline_ctrl;
    localparam int CNT_W = 32;

    localparam logic [7:0] CTL_INIT   = 8'b0010_1010;
    localparam logic [7:0] CTL_RUN    = 8'b1101_0101;
    localparam logic [7:0] CTL_HAZ    = 8'b0001_1101;
    localparam logic [7:0] CTL_BR     = 8'b1111_0101;
    localparam logic [7:0] CTL_MDU    = 8'b0000_0111;
    localparam logic [7:0] CTL_FROZEN = 8'b0000_0000;

    logic             clk;
    logic             rst_n;
    logic             stall_count_clr;
    logic [CNT_W-1:0] stall_count;
    int               checks;
    int               failures;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .MDU_LATENCY (4),
        .MEM_TIMEOUT (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ctrl            (bus.master),
        .stall_count_clr (stall_count_clr),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ctlVec();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                bus.exmem_en, bus.exmem_flush, bus.memwb_en};
    endfunction

    function automatic logic [2:0] statVec();
        return {bus.mdu_busy, bus.mdu_done, bus.mem_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic hs, input logic bt, input logic ms,
                         input logic dr, input logic rdy);
        bus.hazard_stall = hs;
        bus.branch_taken = bt;
        bus.mdu_start    = ms;
        bus.dmem_req     = dr;
        bus.dmem_ready   = rdy;
    endtask

    task automatic clearCount();
        stall_count_clr = 1'b1;
        tick();
        stall_count_clr = 1'b0;
    endtask

    task automatic test_reset();
        setIn(0, 0, 0, 0, 0);
        stall_count_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ctlVec() !== CTL_INIT || statVec() !== 3'b000 || stall_count !== '0) begin
            failures++;
            $display("FAIL reset_hold: ctl=%b stat=%b cnt=%0d, required ctl=%b stat=000 cnt=0",
                     ctlVec(), statVec(), stall_count, CTL_INIT);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_INIT) begin
            failures++;
            $display("FAIL reset_cycle0: ctl=%b, required %b", ctlVec(), CTL_INIT);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_RUN || stall_count !== '0) begin
            failures++;
            $display("FAIL reset_cycle1: ctl=%b cnt=%0d, required ctl=%b cnt=0",
                     ctlVec(), stall_count, CTL_RUN);
        end
        tick();
    endtask

    task automatic test_hazard();
        clearCount();
        setIn(1, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_HAZ) begin
            failures++;
            $display("FAIL hazard_ctl: ctl=%b, required %b", ctlVec(), CTL_HAZ);
        end
        tick();
        setIn(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_RUN || stall_count !== 32'd1) begin
            failures++;
            $display("FAIL hazard_after: ctl=%b cnt=%0d, required ctl=%b cnt=1",
                     ctlVec(), stall_count, CTL_RUN);
        end
        // Clear during a stalled cycle must beat the increment.
        setIn(1, 0, 0, 0, 0);
        stall_count_clr = 1'b1;
        tick();
        setIn(0, 0, 0, 0, 0);
        stall_count_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_count !== 32'd0) begin
            failures++;
            $display("FAIL clr_priority: cnt=%0d, required 0", stall_count);
        end
        tick();
    endtask

    task automatic test_hazard_branch();
        setIn(1, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_HAZ) begin
            failures++;
            $display("FAIL haz_br_both: ctl=%b, required %b", ctlVec(), CTL_HAZ);
        end
        tick();
        setIn(0, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_BR) begin
            failures++;
            $display("FAIL branch_only: ctl=%b, required %b", ctlVec(), CTL_BR);
        end
        tick();
        setIn(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_RUN) begin
            failures++;
            $display("FAIL branch_after: ctl=%b, required %b", ctlVec(), CTL_RUN);
        end
        tick();
    endtask

    task automatic test_mdu();
        clearCount();
        setIn(0, 0, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_MDU || statVec() !== 3'b000) begin
            failures++;
            $display("FAIL mdu_t0: ctl=%b stat=%b, required ctl=%b stat=000",
                     ctlVec(), statVec(), CTL_MDU);
        end
        tick();
        for (int i = 1; i <= 3; i++) begin
            // Hazard and branch requests are ignored while the MDU owns the front end.
            if (i == 1) setIn(1, 1, 1, 0, 0);
            else setIn(0, 0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (ctlVec() !== CTL_MDU || statVec() !== 3'b100) begin
                failures++;
                $display("FAIL mdu_t%0d: ctl=%b stat=%b, required ctl=%b stat=100",
                         i, ctlVec(), statVec(), CTL_MDU);
            end
            tick();
        end
        setIn(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_RUN || statVec() !== 3'b110 || stall_count !== 32'd4) begin
            failures++;
            $display("FAIL mdu_release: ctl=%b stat=%b cnt=%0d, required ctl=%b stat=110 cnt=4",
                     ctlVec(), statVec(), stall_count, CTL_RUN);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_RUN || statVec() !== 3'b000) begin
            failures++;
            $display("FAIL mdu_post: ctl=%b stat=%b, required ctl=%b stat=000",
                     ctlVec(), statVec(), CTL_RUN);
        end
        tick();
    endtask

    task automatic test_mdu_mem();
        clearCount();
        setIn(0, 0, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_MDU) begin
            failures++;
            $display("FAIL mdumem_t0: ctl=%b, required %b", ctlVec(), CTL_MDU);
        end
        tick();
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] want;
            want = (i <= 2) ? CTL_FROZEN : CTL_MDU;
            setIn(0, 0, 0, (i <= 2), 0);
            @(negedge clk);
            checks++;
            if (ctlVec() !== want || statVec() !== 3'b100) begin
                failures++;
                $display("FAIL mdumem_t%0d: ctl=%b stat=%b, required ctl=%b stat=100",
                         i, ctlVec(), statVec(), want);
            end
            tick();
        end
        setIn(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_RUN || statVec() !== 3'b110 || stall_count !== 32'd6) begin
            failures++;
            $display("FAIL mdumem_release: ctl=%b stat=%b cnt=%0d, required ctl=%b stat=110 cnt=6",
                     ctlVec(), statVec(), stall_count, CTL_RUN);
        end
        tick();
    endtask

    task automatic test_timeout();
        clearCount();
        setIn(0, 0, 0, 1, 1);
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_RUN) begin
            failures++;
            $display("FAIL mem_ready: ctl=%b, required %b", ctlVec(), CTL_RUN);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            setIn(0, 0, 0, 1, 0);
            @(negedge clk);
            checks++;
            if (ctlVec() !== CTL_FROZEN || statVec() !== 3'b000) begin
                failures++;
                $display("FAIL memwait_%0d: ctl=%b stat=%b, required ctl=%b stat=000",
                         i, ctlVec(), statVec(), CTL_FROZEN);
            end
            tick();
        end
        setIn(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ctlVec() !== CTL_FROZEN || statVec() !== 3'b001 || stall_count !== 32'd4) begin
                failures++;
                $display("FAIL error_%0d: ctl=%b stat=%b cnt=%0d, required ctl=%b stat=001 cnt=4",
                         i, ctlVec(), statVec(), stall_count, CTL_FROZEN);
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctlVec() !== CTL_INIT || statVec() !== 3'b000 || stall_count !== '0) begin
            failures++;
            $display("FAIL error_reset: ctl=%b stat=%b cnt=%0d, required ctl=%b stat=000 cnt=0",
                     ctlVec(), statVec(), stall_count, CTL_INIT);
        end
        #1;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (ctlVec() !== CTL_RUN || statVec() !== 3'b000) begin
            failures++;
            $display("FAIL error_recover: ctl=%b stat=%b, required ctl=%b stat=000",
                     ctlVec(), statVec(), CTL_RUN);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_hazard();
        test_hazard_branch();
        test_mdu();
        test_mdu_mem();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Arbitrates four freeze/flush sources:
  - data-memory wait;
  - multi-cycle multiply/divide unit (MDU) occupancy;
  - load-use/branch hazard stall from hazard detection;
  - branch-taken flush from ID.
- Drives per-register enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Holds the pipeline frozen for multi-cycle events, with a memory-timeout error trap and a stall performance counter.

Parameters:
- MDU_LATENCY, 4, total frozen cycles per MDU operation; legal range 2..255.
- MEM_TIMEOUT, 64, consecutive memory-wait cycles before the error trap; legal range 2..65535.
- CNT_W, 32, width of stall_count.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- hazard_stall  input  1  hazard detection unit requests one bubble (load-use or branch operand)
- branch_taken  input  1  branch/jump resolved taken in ID
- mdu_start  input  1  MDU instruction present in EX this cycle
- dmem_req  input  1  MEM-stage instruction accessing data memory
- dmem_ready  input  1  data memory completes access this cycle
- stall_count_clr  input  1  synchronous clear of stall_count
- pc_en  output  1  PC write enable
- ifid_en  output  1  IF/ID write enable
- ifid_flush  output  1  IF/ID loads NOP
- idex_en  output  1  ID/EX write enable
- idex_flush  output  1  ID/EX loads bubble (control zeroed)
- exmem_en  output  1  EX/MEM write enable
- exmem_flush  output  1  EX/MEM loads bubble
- memwb_en  output  1  MEM/WB write enable
- mdu_busy  output  1  high in MDU_WAIT
- mdu_done  output  1  one-cycle pulse when MDU result is accepted
- mem_err  output  1  sticky memory-timeout flag
- stall_count  output  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- One clock; reset asynchronous, active-low.
- States: INIT, RUN, MDU_WAIT, ERROR.
- Internal registers:
  - mdu_cnt, 8-bit;
  - to_cnt, 16-bit;
  - stall_count.
- Outputs are a combinational decode of state and inputs.
- rst_n low: state=INIT, counters=0.
- INIT decode:
  - all *_en=0;
  - ifid_flush=idex_flush=exmem_flush=1;
  - mdu_busy=mdu_done=mem_err=0.
  - This is the reset value of every output.
- INIT -> RUN on the first clock edge after rst_n rises, so exactly one pipeline-clearing cycle follows reset.
- mem_freeze = dmem_req & ~dmem_ready, evaluated in RUN and MDU_WAIT. It has top priority:
  - all *_en=0, all flushes=0, mdu_cnt holds.
  - to_cnt increments while mem_freeze is high and clears when it is low.
  - Reaching MEM_TIMEOUT moves to ERROR.
- RUN priority below mem_freeze:
  - (a) mdu_start:
    - pc_en=ifid_en=idex_en=0, exmem_flush=1, exmem_en=memwb_en=1;
    - load mdu_cnt=MDU_LATENCY-1; next state MDU_WAIT.
  - (b) hazard_stall:
    - pc_en=ifid_en=0, idex_flush=1, other enables 1.
  - (c) branch_taken:
    - ifid_flush=1, all enables 1.
  - (d) otherwise all enables 1, flushes 0.
- A suppressed lower-priority request is dropped, not queued. hazard_stall and branch_taken are re-presented by ID while ID is frozen.
- MDU_WAIT:
  - mdu_busy=1.
  - mdu_cnt≠0: same freeze as RUN(a); mdu_cnt decrements.
  - mdu_cnt=0: all enables 1, mdu_done=1; next state RUN.
  - hazard_stall, branch_taken and mdu_start are ignored in MDU_WAIT.
  - Net effect: an mdu_start at cycle T freezes the front end T..T+MDU_LATENCY-1, plus any mem_freeze cycles; release and mdu_done occur at T+MDU_LATENCY.
- ERROR:
  - all *_en=0, flushes=0, mem_err=1.
  - Exit only via reset.
- stall_count:
  - increments in RUN/MDU_WAIT on every cycle with pc_en=0;
  - saturates at all-ones;
  - stall_count_clr has priority over increment;
  - frozen in INIT/ERROR.
- Reset mid-MDU or mid-memory-wait: immediate return to INIT; counters cleared, except that stall_count also clears on reset.

Test Plan:
- Reset release, idle inputs -> cycle 0 after release: enables 0, flushes 1; cycle 1: all enables 1, flushes 0, stall_count=0.
- hazard_stall for 1 cycle -> pc_en=ifid_en=0, idex_flush=1 for exactly that cycle; stall_count=1.
- mdu_start at T, MDU_LATENCY=4 -> pc_en=0 and exmem_flush=1 for T..T+3; mdu_done=1 and pc_en=1 at T+4; stall_count=4.
- mdu_start at T with dmem_req=1, dmem_ready=0 for T+1..T+2 -> all enables 0 in T+1..T+2; mdu_done moves to T+6; stall_count=6.
- hazard_stall and branch_taken together -> stall wins (ifid_flush=0, idex_flush=1); branch_taken alone next cycle -> ifid_flush=1 only.
- dmem_ready held 0 with MEM_TIMEOUT=4 -> ERROR after 4 cycles, mem_err=1 sticky; rst_n pulse mid-ERROR -> INIT, mem_err=0.
